vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter MAX_X, default 319, last valid write column.
REQ-002 SHALL have parameter MAX_Y, default 239, last valid write row.
REQ-003 SHALL have parameter BG_COLOUR, default 3'b001, colour written during frame clear.
REQ-004 SHALL have port clock  input  1  single system clock (50 MHz), all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port x_in  input  9  pixel column from the draw stream.
REQ-007 SHALL have port y_in  input  9  pixel row from the draw stream.
REQ-008 SHALL have port colour_in  input  3  pixel colour {R,G,B}.
REQ-009 SHALL have port plot  input  1  write strobe; one pixel accepted per clock when high.
REQ-010 SHALL have port ready  output  1  high when clear finished and writes are accepted.
REQ-011 SHALL have port frame_start  output  1  one-clock pulse at the start of each scanned frame.
REQ-012 SHALL have ports vga_r, vga_g, vga_b  output  8 each  colour channels.
REQ-013 SHALL have ports vga_hs, vga_vs  output  1 each  active-low syncs.
REQ-014 SHALL have port vga_blank_n  output  1  low outside the visible area.
REQ-015 SHALL have port vga_clk  output  1  pixel clock = pixel-enable toggle (25 MHz).

Function
REQ-016 SHALL run a two-state FSM: CLEAR, RUN; enters CLEAR on reset.
REQ-017 CLEAR SHALL write BG_COLOUR to addresses 0..(MAX_X+1)*(MAX_Y+1)-1, one per clock, ascending; plot ignored; ready=0.
REQ-018 CLEAR SHALL move to RUN on the clock after the last address is written (76800 clocks for defaults); ready=1 from that clock.
REQ-019 In RUN, plot=1 with x_in<=MAX_X and y_in<=MAX_Y SHALL write colour_in at address y_in*(MAX_X+1)+x_in; out-of-range writes SHALL be dropped silently.
REQ-020 Pixel enable SHALL toggle every clock, starting 0 after reset; counters advance only when it is 1.
REQ-021 Horizontal counter 0..799: visible 0..639, vga_hs low for 656..751, wraps 799->0.
REQ-022 Vertical counter 0..524, advances when horizontal wraps: visible 0..479, vga_vs low for 490..491, wraps 524->0.
REQ-023 Read address SHALL be (v>>1)*(MAX_X+1)+(h>>1), 2x pixel doubling of the 320x240 frame.
REQ-024 Memory read latency 1 clock; vga_hs, vga_vs, vga_blank_n SHALL be delayed to align exactly with the colour they accompany; total counter-to-pin latency 2 clocks.
REQ-025 Each colour bit SHALL expand to 8'hFF (1) or 8'h00 (0); channels SHALL be 8'h00 when blanked.
REQ-026 Simultaneous write and read to the same address SHALL return old data (read-before-write).
REQ-027 frame_start SHALL pulse for one clock when counters pass h=0, v=0 with pixel enable high.
REQ-028 Scanout SHALL run during CLEAR as well (displaying memory content as cleared).

Reset
REQ-029 resetn low SHALL immediately force: FSM=CLEAR, clear address 0, counters 0, pixel enable 0, ready=0, frame_start=0, vga_hs=1, vga_vs=1, vga_blank_n=0, colour outputs 0.
REQ-030 Reset mid-CLEAR or mid-RUN SHALL restart the clear from address 0; memory contents are not reset asynchronously.

Structure
REQ-031 Timing constants (visible/porch/sync/total per axis), coordinate and colour widths, and FSM state encoding SHALL live in shared package vga_pkg.
REQ-032 Memory SHALL be sub-module frame_ram: simple dual-port, 17-bit address, 3-bit data, synchronous read, one write port shared by clear and plot via a mux.

Verification
REQ-033 Reset release -> ready rises exactly 76800 clocks later; frame read back shows 3'b001 everywhere.
REQ-034 After ready, plot x=10 y=20 colour=3'b100 -> screen pixels (20..21, 40..41) show r=8'hFF, g=b=8'h00; neighbours show background.
REQ-035 plot x=320 y=5 and x=5 y=240 -> no memory change anywhere.
REQ-036 Free-run one frame -> hs period 1600 clocks, low 192 clocks; vs period 840000 clocks, low 3200 clocks; frame_start once per 840000 clocks.
REQ-037 Blanking -> vga_blank_n low and rgb zero for h>=640 or v>=480, with 2-clock alignment to sync edges checked.
REQ-038 Assert resetn low for 3 clocks at clear address 40000 -> outputs at reset values asynchronously, clear restarts, ready rises 76800 clocks after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing, width and FSM constants for the scanout block.
// 640x480@60 timing with a 320x240 3-bit frame doubled 2x on both axes.
package vga_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int CNT_W   = 10;
    localparam int COORD_W = 9;
    localparam int COL_W   = 3;
    localparam int ADDR_W  = 17;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    function automatic logic [7:0] expand_bit(input logic b);
        return b ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/vga_scanout_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// A read and write to the same address in one clock returns the old data.
module frame_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = 76800
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [COL_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [COL_W-1:0]  o_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [COL_W-1:0] r_mem [DEPTH];
    logic [COL_W-1:0] r_rdata;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign w_wr_ok = i_we && (i_waddr < ADDR_W'(DEPTH));
    assign w_rd_ok = i_raddr < ADDR_W'(DEPTH);

    always_ff @(posedge clock) begin
        if (w_wr_ok) begin
            r_mem[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    // Scan positions beyond the stored frame read as black.
    always_ff @(posedge clock) begin
        if (w_rd_ok) begin
            r_rdata <= r_mem[i_raddr[AW-1:0]];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffered VGA scanout: clears the frame to a background colour,
// then accepts pixel writes while continuously scanning 640x480.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int               MAX_X     = 319,
    parameter int               MAX_Y     = 239,
    parameter logic [COL_W-1:0] BG_COLOUR = 3'b001
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [COL_W-1:0]   colour_in,
    input  logic               plot,
    output logic               ready,
    output logic               frame_start,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_clk
);

    localparam int DEPTH = (MAX_X + 1) * (MAX_Y + 1);

    localparam logic [ADDR_W-1:0]  ROW_W = ADDR_W'(MAX_X + 1);
    localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [COORD_W-1:0] XLIM  = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] YLIM  = COORD_W'(MAX_Y);

    localparam logic [CNT_W-1:0] H_END = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_END = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_S0  = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_S1  = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_S0  = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_S1  = CNT_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_V   = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_V   = CNT_W'(V_VIS);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_addr;

    logic              w_plot_ok;
    logic [ADDR_W-1:0] w_plot_addr;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [COL_W-1:0]  w_wdata;

    logic              r_pen;
    logic [CNT_W-1:0]  r_h;
    logic [CNT_W-1:0]  r_v;
    logic              r_frame_start;

    logic [ADDR_W-1:0] w_raddr;
    logic [COL_W-1:0]  w_rdata;
    sync_t             w_sync;
    sync_t             r_sync1;
    sync_t             r_sync2;
    logic [7:0]        r_r;
    logic [7:0]        r_g;
    logic [7:0]        r_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_clr_addr == LAST) begin
                r_state    <= ST_RUN;
                r_clr_addr <= '0;
            end else begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    assign ready = (r_state == ST_RUN);

    assign w_plot_ok   = plot && (x_in <= XLIM) && (y_in <= YLIM);
    assign w_plot_addr = ADDR_W'(y_in) * ROW_W + ADDR_W'(x_in);

    // Clear owns the single write port until the last address is written.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = BG_COLOUR;
        end else begin
            w_we    = w_plot_ok;
            w_waddr = w_plot_addr;
            w_wdata = colour_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pen         <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pen         <= ~r_pen;
            r_frame_start <= r_pen && (r_h == '0) && (r_v == '0);
            if (r_pen) begin
                if (r_h == H_END) begin
                    r_h <= '0;
                    if (r_v == V_END) begin
                        r_v <= '0;
                    end else begin
                        r_v <= r_v + 1'b1;
                    end
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    assign w_raddr = ADDR_W'(r_v[CNT_W-1:1]) * ROW_W
                   + ADDR_W'(r_h[CNT_W-1:1]);

    always_comb begin
        w_sync.hs      = !((r_h >= H_S0) && (r_h < H_S1));
        w_sync.vs      = !((r_v >= V_S0) && (r_v < V_S1));
        w_sync.blank_n = (r_h < H_V) && (r_v < V_V);
    end

    frame_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clock  (clock),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(w_raddr),
        .o_rdata(w_rdata)
    );

    // Sync stage 1 lines up with the RAM read; stage 2 with the pins.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= SYNC_RST;
            r_sync2 <= SYNC_RST;
            r_r     <= 8'h00;
            r_g     <= 8'h00;
            r_b     <= 8'h00;
        end else begin
            r_sync1 <= w_sync;
            r_sync2 <= r_sync1;
            r_r     <= expand_bit(r_sync1.blank_n & w_rdata[2]);
            r_g     <= expand_bit(r_sync1.blank_n & w_rdata[1]);
            r_b     <= expand_bit(r_sync1.blank_n & w_rdata[0]);
        end
    end

    assign frame_start = r_frame_start;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign vga_hs      = r_sync2.hs;
    assign vga_vs      = r_sync2.vs;
    assign vga_blank_n = r_sync2.blank_n;
    assign vga_clk     = r_pen;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a reduced 16x8 frame.
// A timeline model predicts every pin on every clock after reset.
module tb_vga_scanout;

    localparam int MX    = 15;
    localparam int MY    = 7;
    localparam int W     = MX + 1;
    localparam int DEPTH = W * (MY + 1);
    localparam logic [2:0] BG = 3'b001;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic [8:0] x_in = '0;
    logic [8:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic       plot = 1'b0;
    logic       ready;
    logic       frame_start;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_clk;

    vga_scanout #(
        .MAX_X    (MX),
        .MAX_Y    (MY),
        .BG_COLOUR(BG)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .plot       (plot),
        .ready      (ready),
        .frame_start(frame_start),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_clk    (vga_clk)
    );

    always #10 clock = ~clock;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       known;
    } video_t;

    typedef struct {
        int         h;
        int         v;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } probe_t;

    typedef struct {
        int x;
        int y;
        int c;
    } plot_t;

    localparam video_t VRST = '{hs: 1'b1, vs: 1'b1, bn: 1'b0,
                               r: 8'h00, g: 8'h00, b: 8'h00, known: 1'b1};

    int     checks = 0;
    int     failures = 0;
    int     n = 0;
    int     mem_m [DEPTH];
    video_t expq [$];
    int     hs_fall [$];
    int     hs_rise [$];
    int     bn_fall [$];
    int     fs_count = 0;
    int     ready_n = -1;
    logic   prev_hs = 1'b1;
    logic   prev_bn = 1'b0;
    bit     probe_on = 1'b0;
    probe_t probes [12];
    plot_t  plots [5];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    function automatic logic [7:0] ex(int c, int bitpos);
        return ((c >> bitpos) & 1) != 0 ? 8'hFF : 8'h00;
    endfunction

    // Pins for screen position q (pixel-clock ticks since reset), given memory now.
    function automatic video_t video_at(int q);
        video_t e;
        int h, v, a, c;
        h = q % 800;
        v = (q / 800) % 525;
        e.hs = !(h >= 656 && h < 752);
        e.vs = !(v >= 490 && v < 492);
        e.bn = (h < 640) && (v < 480);
        e.r = 8'h00;
        e.g = 8'h00;
        e.b = 8'h00;
        e.known = 1'b1;
        if (e.bn) begin
            a = (v / 2) * W + (h / 2);
            if (a < DEPTH) begin
                c = mem_m[a];
                if (c < 0) begin
                    e.known = 1'b0;
                end else begin
                    e.r = ex(c, 2);
                    e.g = ex(c, 1);
                    e.b = ex(c, 0);
                end
            end
        end
        return e;
    endfunction

    task automatic cyc(input bit pl, input int x, input int y, input int c);
        video_t      e;
        logic [29:0] act;
        logic [29:0] exp;
        logic        fs_e;
        int          q;
        plot      = pl;
        x_in      = x[8:0];
        y_in      = y[8:0];
        colour_in = c[2:0];
        @(posedge clock);
        n++;
        if (n <= DEPTH) begin
            mem_m[n-1] = BG;
        end else if (pl && x <= MX && y <= MY) begin
            mem_m[y*W + x] = c;
        end
        @(negedge clock);
        e = expq.pop_front();
        fs_e = (n >= 2) && (n % 2 == 0) && (((n - 2) / 2) % 840000 == 0);
        act = {ready, frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n,
               vga_r, vga_g, vga_b};
        exp = {(n >= DEPTH), fs_e, (n % 2 == 1), e.hs, e.vs, e.bn,
               e.r, e.g, e.b};
        if (!e.known) begin
            act[23:0] = '0;
            exp[23:0] = '0;
        end
        check("pins", 64'(act), 64'(exp));
        expq.push_back(video_at(n / 2));
        if (probe_on && n >= 2) begin
            q = (n - 2) / 2;
            foreach (probes[i]) begin
                if (probes[i].h == q % 800 && probes[i].v == q / 800) begin
                    check("probe", {vga_blank_n, vga_r, vga_g, vga_b},
                          {probes[i].bn, probes[i].r, probes[i].g, probes[i].b});
                end
            end
        end
        if (prev_hs && !vga_hs) hs_fall.push_back(n);
        if (!prev_hs && vga_hs) hs_rise.push_back(n);
        if (prev_bn && !vga_blank_n) bn_fall.push_back(n);
        prev_hs = vga_hs;
        prev_bn = vga_blank_n;
        if (frame_start) fs_count++;
        if (ready && ready_n < 0) ready_n = n;
    endtask

    task automatic do_reset(input int hold);
        #2 resetn = 1'b0;
        #1;
        check("reset_pins",
              {ready, frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n,
               vga_r, vga_g, vga_b},
              {3'b000, 3'b110, 24'h0});
        plot = 1'b0;
        repeat (hold) @(posedge clock);
        // The clear write port stays pointed at address 0 while held.
        mem_m[0] = BG;
        @(negedge clock);
        resetn = 1'b1;
        n = 0;
        expq.delete();
        expq.push_back(VRST);
        expq.push_back(video_at(0));
        hs_fall.delete();
        hs_rise.delete();
        bn_fall.delete();
        prev_hs = 1'b1;
        prev_bn = 1'b0;
        fs_count = 0;
        ready_n = -1;
    endtask

    task automatic run_mixed(input int until_n);
        int q, hh, vv, ry;
        while (n < until_n) begin
            q  = n / 2;
            hh = q % 800;
            vv = q / 800;
            if ($urandom_range(0, 1) == 1 && hh / 2 <= MX
                && vv / 2 >= 1 && vv / 2 <= 3) begin
                cyc(1'b1, hh / 2, vv / 2, int'($urandom_range(0, 7)));
            end else if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: ry = 1;
                    1: ry = 2;
                    2: ry = 3;
                    3: ry = 8;
                    default: ry = 9;
                endcase
                cyc(1'b1, int'($urandom_range(0, 19)), ry,
                    int'($urandom_range(0, 7)));
            end else begin
                cyc(1'b0, 0, 0, 0);
            end
        end
    endtask

    initial begin
        foreach (mem_m[i]) mem_m[i] = -1;
        probes[0]  = '{20, 10, 1'b1, 8'hFF, 8'h00, 8'h00};
        probes[1]  = '{21, 11, 1'b1, 8'hFF, 8'h00, 8'h00};
        probes[2]  = '{19, 10, 1'b1, 8'h00, 8'h00, 8'hFF};
        probes[3]  = '{22, 10, 1'b1, 8'h00, 8'h00, 8'hFF};
        probes[4]  = '{20,  9, 1'b1, 8'h00, 8'h00, 8'hFF};
        probes[5]  = '{20, 12, 1'b1, 8'h00, 8'h00, 8'hFF};
        probes[6]  = '{30, 14, 1'b1, 8'h00, 8'hFF, 8'hFF};
        probes[7]  = '{31, 15, 1'b1, 8'h00, 8'hFF, 8'hFF};
        probes[8]  = '{ 1,  1, 1'b1, 8'hFF, 8'hFF, 8'h00};
        probes[9]  = '{ 0,  8, 1'b1, 8'h00, 8'h00, 8'hFF};
        probes[10] = '{700, 5, 1'b0, 8'h00, 8'h00, 8'h00};
        probes[11] = '{640, 3, 1'b0, 8'h00, 8'h00, 8'h00};
        plots[0] = '{10,  5, 3'b100};
        plots[1] = '{15,  7, 3'b011};
        plots[2] = '{ 0,  0, 3'b110};
        plots[3] = '{16,  3, 3'b111};
        plots[4] = '{ 5,  8, 3'b111};

        do_reset(3);
        while (n < DEPTH) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        check("ready_rise_1", 64'(ready_n), 64'(DEPTH));

        probe_on = 1'b1;
        foreach (plots[i]) cyc(1'b1, plots[i].x, plots[i].y, plots[i].c);
        run_mixed(1600 * 16 + 400);
        probe_on = 1'b0;

        check("hs_fall_count", 64'(hs_fall.size() >= 4), 64'(1));
        check("blank_first_fall", 64'(bn_fall.size() > 0 ? bn_fall[0] : -1),
              64'(1282));
        if (hs_fall.size() >= 4 && hs_rise.size() >= 3) begin
            check("hs_first_fall", 64'(hs_fall[0]), 64'(1314));
            for (int i = 0; i < 3; i++) begin
                check("hs_period", 64'(hs_fall[i+1] - hs_fall[i]), 64'(1600));
                check("hs_low", 64'(hs_rise[i] - hs_fall[i]), 64'(192));
            end
        end
        check("frame_start_count_1", 64'(fs_count), 64'(1));

        do_reset(3);
        while (n < 60) cyc(1'b0, 0, 0, 0);
        do_reset(3);
        while (n < DEPTH) begin
            cyc(1'b1, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        check("ready_rise_2", 64'(ready_n), 64'(DEPTH));
        while (n < 1600 * 16 + 40) cyc(1'b0, 0, 0, 0);
        check("frame_start_count_2", 64'(fs_count), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
